// File: rtl/fifo_read_streamer.sv
// Prefetching adapter from an async-FIFO pop port to a valid/ready stream.
// Hides the FIFO's registered read latency and tags every BURST_LEN-th beat.
module fifo_read_streamer #(
  parameter int DATA_W    = 3,
  parameter int BUF_DEPTH = 3,
  parameter int BURST_LEN = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             fifo_empty,
  input  logic [DATA_W-1:0]                fifo_rdata,
  output logic                             fifo_pop,
  input  logic                             en,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_W-1:0]                out_data,
  output logic                             out_last,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   level
);

  localparam int LW = $clog2(BUF_DEPTH+1);
  localparam int IW = $clog2(BUF_DEPTH);
  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [IW-1:0] IDX_MAX = IW'(BUF_DEPTH-1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_LEN-1);
  localparam logic [LW:0]   DEPTH_X = (LW+1)'(BUF_DEPTH);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [DATA_W-1:0] mem_d [BUF_DEPTH];
  logic [IW-1:0]     rd_idx_q, rd_idx_d;
  logic [IW-1:0]     wr_idx_q, wr_idx_d;
  logic [LW-1:0]     level_q, level_d;
  logic              inflight_q, inflight_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              room;
  logic              hs;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
    return (i == IDX_MAX) ? '0 : i + 1'b1;
  endfunction

  // Reserve a slot for the in-flight word so a capture can never overflow.
  assign room      = ({1'b0, level_q} + (LW+1)'(inflight_q)) < DEPTH_X;
  assign fifo_pop  = reset & en & ~fifo_empty & room;
  assign out_valid = (level_q != '0);
  assign hs        = out_valid & out_ready;
  assign out_data  = mem_q[rd_idx_q];
  assign out_last  = out_valid & (cnt_q == CNT_MAX);
  assign level     = level_q;

  always_comb begin
    mem_d      = mem_q;
    rd_idx_d   = rd_idx_q;
    wr_idx_d   = wr_idx_q;
    level_d    = level_q;
    cnt_d      = cnt_q;
    inflight_d = fifo_pop;
    if (inflight_q) begin
      mem_d[wr_idx_q] = fifo_rdata;
      wr_idx_d        = nxt(wr_idx_q);
    end
    if (hs) begin
      rd_idx_d = nxt(rd_idx_q);
      cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
    unique case (1'b1)
      inflight_q & ~hs: level_d = level_q + 1'b1;
      hs & ~inflight_q: level_d = level_q - 1'b1;
      default:          level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '{default: '0};
      rd_idx_q   <= '0;
      wr_idx_q   <= '0;
      level_q    <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      mem_q      <= mem_d;
      rd_idx_q   <= rd_idx_d;
      wr_idx_q   <= wr_idx_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
